// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// The controller owns every select/enable. The datapath supplies the opcode and the memory handshake.
interface multicycle_controller_if #(
    parameter int RETIRE_W = 16
);
    logic [5:0]          opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic [1:0]          pc_src;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_ctrl;
    logic                illegal_op;
    logic [RETIRE_W-1:0] retired;
    logic [3:0]          state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_ctrl, illegal_op, retired, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_ctrl, illegal_op, retired, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back and stalls on the shared memory handshake.
module multicycle_controller #(
    parameter int RETIRE_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALU_CTRL_MTYPE = 2'b00;
    localparam logic [1:0] ALU_CTRL_BTYPE = 2'b01;
    localparam logic [1:0] ALU_CTRL_RTYPE = 2'b10;
    localparam logic [1:0] ALU_CTRL_JTYPE = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    // Per-state Moore decode. fetch_gate marks the two FETCH enables that
    // must additionally wait for mem_ready.
    typedef struct packed {
        logic       fetch_gate;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_ctrl;
    } ctrl_t;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = ALU_CTRL_JTYPE;
        case (s)
            S_FETCH: begin
                c.mem_read   = 1'b1;
                c.alu_src_b  = 2'b01;
                c.alu_ctrl   = ALU_CTRL_MTYPE;
                c.fetch_gate = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_ctrl  = ALU_CTRL_MTYPE;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_ctrl  = ALU_CTRL_MTYPE;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_ctrl  = ALU_CTRL_RTYPE;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_ctrl      = ALU_CTRL_BTYPE;
                c.pc_write_cond = 1'b1;
                c.pc_src        = 2'b01;
            end
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b10;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
            end
            default: begin
                c = '0;
                c.alu_ctrl = ALU_CTRL_JTYPE;
            end
        endcase
        return c;
    endfunction

    state_t              state_reg;
    state_t              state_next;
    ctrl_t               ctrl_reg;
    logic [RETIRE_W-1:0] retired_reg;
    logic                retire_next;
    logic                op_legal;

    always_comb begin
        op_legal = bus.opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    end

    // retire_next flags the instruction-completing transitions back to FETCH.
    always_comb begin
        state_next  = state_reg;
        retire_next = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (bus.mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_R:         state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EXEC;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                state_next = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                if (bus.mem_ready) state_next = S_MEM_WB;
            end
            S_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    state_next  = S_FETCH;
                    retire_next = 1'b1;
                end
            end
            S_EXECUTE:   state_next = S_R_WB;
            S_ADDI_EXEC: state_next = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                state_next  = S_FETCH;
                retire_next = 1'b1;
            end
            default:     state_next = S_FETCH;
        endcase
    end

    // The decode is registered alongside the state, so ctrl_reg always equals
    // decode(state_reg) without a decode path behind the state flops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= S_FETCH;
            ctrl_reg    <= decode(S_FETCH);
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= decode(state_next);
            if (retire_next) retired_reg <= retired_reg + RETIRE_W'(1);
        end
    end

    // Enables are masked during reset so an abandoned instruction cannot write.
    assign bus.pc_write      = rst & (ctrl_reg.pc_write | (ctrl_reg.fetch_gate & bus.mem_ready));
    assign bus.ir_write      = rst & ctrl_reg.fetch_gate & bus.mem_ready;
    assign bus.pc_write_cond = rst & ctrl_reg.pc_write_cond;
    assign bus.mem_read      = rst & ctrl_reg.mem_read;
    assign bus.mem_write     = rst & ctrl_reg.mem_write;
    assign bus.reg_write     = rst & ctrl_reg.reg_write;
    assign bus.illegal_op    = rst & (state_reg == S_DECODE) & ~op_legal;

    assign bus.pc_src     = ctrl_reg.pc_src;
    assign bus.i_or_d     = ctrl_reg.i_or_d;
    assign bus.reg_dst    = ctrl_reg.reg_dst;
    assign bus.mem_to_reg = ctrl_reg.mem_to_reg;
    assign bus.alu_src_a  = ctrl_reg.alu_src_a;
    assign bus.alu_src_b  = ctrl_reg.alu_src_b;
    assign bus.alu_ctrl   = ctrl_reg.alu_ctrl;
    assign bus.retired    = retired_reg;
    assign bus.state      = state_reg;
endmodule
